hc00_tester: RTL and testbench
==============================

HC00_TESTER -- requirements
Module: hc00_tester

Interface
REQ-001 SHALL have parameter NUM_GATES, default 4, meaning the number of 2-input NAND gates exercised in parallel.
REQ-002 SHALL have parameter SETTLE_CYCLES, default 4, meaning the clock cycles between driving a vector and sampling the response; legal range 2..255.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic is on the rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port start, input, 1 bit: single-cycle request to run one full test.
REQ-006 SHALL have port a_drv, output, NUM_GATES bits: drives the a pin of each gate under test.
REQ-007 SHALL have port b_drv, output, NUM_GATES bits: drives the b pin of each gate under test.
REQ-008 SHALL have port y_in, input, NUM_GATES bits: gate output pins, asynchronous to clk.
REQ-009 SHALL have port busy, output, 1 bit: high while a test is running.
REQ-010 SHALL have port done, output, 1 bit: one-cycle pulse at test end.
REQ-011 SHALL have port pass, output, 1 bit: result of the last completed test.
REQ-012 SHALL have port fail_mask, output, NUM_GATES bits: bit i set means gate i mismatched at least one vector.

Function
REQ-013 SHALL implement FSM states IDLE, DRIVE, SETTLE, SAMPLE, DONE.
REQ-014 SHALL synchronize y_in through a two-flop synchronizer before any comparison.
REQ-015 SHALL, when in IDLE with start=1 at a clk edge, enter DRIVE on the next cycle, clear fail_mask, clear pass, and set vec=0.
REQ-016 SHALL apply vec as a 2-bit vector in the order 00, 01, 10, 11, with the MSB on a and the LSB on b; the same value goes to all gates.
REQ-017 SHALL register a_drv and b_drv so the new vector appears in the first DRIVE cycle; DRIVE lasts exactly 1 cycle, then the FSM enters SETTLE.
REQ-018 SHALL stay in SETTLE for exactly SETTLE_CYCLES cycles, counted by a settle counter, then enter SAMPLE.
REQ-019 SHALL, in SAMPLE (1 cycle), OR into fail_mask the value synced_y XOR ~(a_drv & b_drv), bitwise per gate.
REQ-020 SHALL, after SAMPLE, go to DONE if vec==3; otherwise it SHALL increment vec and go to DRIVE.
REQ-021 SHALL, in DONE (1 cycle), assert done=1, set pass=1 only if fail_mask==0, then return to IDLE.
REQ-022 SHALL drive busy=1 exactly in DRIVE, SETTLE and SAMPLE; busy SHALL be 0 in IDLE and DONE.
REQ-023 SHALL hold pass and fail_mask stable from DONE until the next accepted start or reset.
REQ-024 SHALL ignore start outside IDLE, including in DONE.
REQ-025 SHALL keep a_drv and b_drv at the last vector (11) after the test until the next start or reset.
REQ-026 SHALL give a test duration of 4*(SETTLE_CYCLES+2) cycles of busy followed by a 1-cycle done; with the default this is 24 busy cycles, and done falls in cycle 25 after the start edge.

Reset
REQ-027 SHALL, on rst=1 at a clk edge, set state=IDLE, vec=0, settle counter=0, both synchronizer stages=0, a_drv=0, b_drv=0, busy=0, done=0, pass=0 and fail_mask=0.
REQ-028 SHALL let rst take priority over start and over every state transition, including mid-test; an aborted test SHALL produce no done pulse.

Structure
REQ-029 SHALL place the state enum typedef, the default NUM_GATES=4, and the expected-NAND function in shared package hc00_pkg.
REQ-030 SHALL instantiate the synchronizer as sub-module sync2, parameterised by width and reset to 0 by rst.

Verification
REQ-031 SHALL verify the ideal model: y_in=~(a_drv&b_drv) with 1-cycle delay, start pulsed -> busy 24 cycles, done in cycle 25, pass=1, fail_mask=0000.
REQ-032 SHALL verify gate 2 stuck at 1 -> vector 11 mismatches, fail_mask=0100, pass=0.
REQ-033 SHALL verify gate 0 stuck at 0 and gate 3 shorted to a_drv[3] -> fail_mask=1001, pass=0.
REQ-034 SHALL verify start re-pulsed at cycles 3 and 24 of a running test -> no restart, exactly one done, vector order unchanged.
REQ-035 SHALL verify rst asserted during vec=2 SETTLE -> next cycle a_drv=b_drv=0, busy=0, no done; a following start runs a full clean test.
REQ-036 SHALL verify a model delaying y_in by SETTLE_CYCLES+3 cycles -> at least one fail_mask bit set, pass=0.

Source files
------------

// File: rtl/hc00_pkg.sv
// hc00_pkg: shared types, defaults and the reference NAND for the 74HC00 tester.
package hc00_pkg;
  typedef enum logic [2:0] {IDLE, DRIVE, SETTLE, SAMPLE, DONE} state_t;
  localparam int DEF_NUM_GATES = 4;
  function automatic logic nand2(input logic a, input logic b);
    return ~(a & b);
  endfunction
endpackage

// File: rtl/sync2.sv
// sync2: two-flop synchronizer for signals asynchronous to clk.
module sync2 #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  logic [WIDTH-1:0] meta;
  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= '0;
      q <= '0;
    end else begin
      meta <= d;
      q <= meta;
    end
  end
endmodule

// File: rtl/hc00_tester.sv
// hc00_tester: drives all four NAND input vectors into each gate and flags gates whose output mismatches.
module hc00_tester
  import hc00_pkg::*;
#(
  parameter int NUM_GATES = DEF_NUM_GATES,
  parameter int SETTLE_CYCLES = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  output logic [NUM_GATES-1:0] a_drv,
  output logic [NUM_GATES-1:0] b_drv,
  input  logic [NUM_GATES-1:0] y_in,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [NUM_GATES-1:0] fail_mask
);
  localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES - 1);
  state_t state, state_n;
  logic [1:0] vec, vec_n;
  logic [7:0] cnt;
  logic [NUM_GATES-1:0] sync_y, exp_y, mask_n;
  sync2 #(.WIDTH(NUM_GATES)) u_sync (.clk(clk), .rst(rst), .d(y_in), .q(sync_y));
  assign vec_n = (state == IDLE) ? 2'd0 : vec + 2'd1;
  assign busy = (state == DRIVE) || (state == SETTLE) || (state == SAMPLE);
  assign done = (state == DONE);
  always_comb begin
    exp_y = '0;
    for (int i = 0; i < NUM_GATES; i++) exp_y[i] = nand2(a_drv[i], b_drv[i]);
    mask_n = fail_mask | (sync_y ^ exp_y);
  end
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = start ? DRIVE : IDLE;
      DRIVE:   state_n = SETTLE;
      SETTLE:  state_n = (cnt == SETTLE_LAST) ? SAMPLE : SETTLE;
      SAMPLE:  state_n = (vec == 2'd3) ? DONE : DRIVE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else state <= state_n;
  end
  // The vector is loaded on the edge entering DRIVE so the pins change in the first DRIVE cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      vec <= '0;
      cnt <= '0;
      a_drv <= '0;
      b_drv <= '0;
      pass <= 1'b0;
      fail_mask <= '0;
    end else begin
      cnt <= (state == SETTLE) ? cnt + 8'd1 : 8'd0;
      if (state_n == DRIVE) begin
        vec <= vec_n;
        a_drv <= {NUM_GATES{vec_n[1]}};
        b_drv <= {NUM_GATES{vec_n[0]}};
      end
      if (state == IDLE && start) begin
        fail_mask <= '0;
        pass <= 1'b0;
      end
      if (state == SAMPLE) begin
        fail_mask <= mask_n;
        if (vec == 2'd3) pass <= ~|mask_n;
      end
    end
  end
endmodule

// File: tb/tb_hc00_tester.sv
// tb_hc00_tester: directed tests of hc00_tester against ideal and faulty NAND gate models.
module tb_hc00_tester;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic [3:0] a_drv, b_drv, y_in, fail_mask;
  logic busy, done, pass;
  logic [1:0] mode = 2'd0;
  logic [3:0] dl [7];
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  hc00_tester dut (
    .clk(clk), .rst(rst), .start(start), .a_drv(a_drv), .b_drv(b_drv), .y_in(y_in),
    .busy(busy), .done(done), .pass(pass), .fail_mask(fail_mask)
  );

  always @(posedge clk) begin
    dl[0] <= ~(a_drv & b_drv);
    for (int i = 1; i < 7; i++) dl[i] <= dl[i-1];
  end

  always_comb begin
    case (mode)
      2'd0:    y_in = dl[0];
      2'd1:    y_in = dl[0] | 4'b0100;
      2'd2:    y_in = {a_drv[3], dl[0][2:1], 1'b0};
      default: y_in = dl[6];
    endcase
  end

  task automatic run(input int re1, input int re2, input int re3,
                     output int busy_n, output int done_n, output int done_cyc, output logic [7:0] order);
    busy_n = 0;
    done_n = 0;
    done_cyc = 0;
    order = '0;
    @(negedge clk);
    start = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      start = (c == re1) || (c == re2) || (c == re3);
      if (busy) busy_n++;
      if (done) begin
        done_n++;
        done_cyc = c;
      end
      if (c == 1 || c == 7 || c == 13 || c == 19) order = {order[5:0], a_drv[0], b_drv[0]};
    end
    start = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    total += 5;
    if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", done); end
    if (pass !== 1'b0) begin bad++; $display("FAIL reset_pass got=%b want=0", pass); end
    if (fail_mask !== 4'b0000) begin bad++; $display("FAIL reset_mask got=%b want=0000", fail_mask); end
    if ({a_drv, b_drv} !== 8'h00) begin bad++; $display("FAIL reset_drv got=%h want=00", {a_drv, b_drv}); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_ideal;
    int bn, dn, dc;
    logic [7:0] ord;
    mode = 2'd0;
    run(0, 0, 0, bn, dn, dc, ord);
    total += 8;
    if (bn !== 24) begin bad++; $display("FAIL ideal_busy_cycles got=%0d want=24", bn); end
    if (dn !== 1) begin bad++; $display("FAIL ideal_done_count got=%0d want=1", dn); end
    if (dc !== 25) begin bad++; $display("FAIL ideal_done_cycle got=%0d want=25", dc); end
    if (ord !== 8'h1B) begin bad++; $display("FAIL ideal_order got=%h want=1b", ord); end
    if (pass !== 1'b1) begin bad++; $display("FAIL ideal_pass got=%b want=1", pass); end
    if (fail_mask !== 4'b0000) begin bad++; $display("FAIL ideal_mask got=%b want=0000", fail_mask); end
    if (a_drv !== 4'hF) begin bad++; $display("FAIL ideal_a_hold got=%h want=f", a_drv); end
    if (b_drv !== 4'hF) begin bad++; $display("FAIL ideal_b_hold got=%h want=f", b_drv); end
  endtask

  task automatic test_stuck_high;
    int bn, dn, dc;
    logic [7:0] ord;
    mode = 2'd1;
    run(0, 0, 0, bn, dn, dc, ord);
    total += 3;
    if (fail_mask !== 4'b0100) begin bad++; $display("FAIL stuck1_mask got=%b want=0100", fail_mask); end
    if (pass !== 1'b0) begin bad++; $display("FAIL stuck1_pass got=%b want=0", pass); end
    if (dn !== 1) begin bad++; $display("FAIL stuck1_done_count got=%0d want=1", dn); end
  endtask

  task automatic test_stuck_low_short;
    int bn, dn, dc;
    logic [7:0] ord;
    mode = 2'd2;
    run(0, 0, 0, bn, dn, dc, ord);
    total += 2;
    if (fail_mask !== 4'b1001) begin bad++; $display("FAIL short_mask got=%b want=1001", fail_mask); end
    if (pass !== 1'b0) begin bad++; $display("FAIL short_pass got=%b want=0", pass); end
  endtask

  task automatic test_back_to_back;
    int bn, dn, dc;
    logic [7:0] ord;
    mode = 2'd0;
    run(3, 24, 25, bn, dn, dc, ord);
    total += 5;
    if (bn !== 24) begin bad++; $display("FAIL restart_busy_cycles got=%0d want=24", bn); end
    if (dn !== 1) begin bad++; $display("FAIL restart_done_count got=%0d want=1", dn); end
    if (dc !== 25) begin bad++; $display("FAIL restart_done_cycle got=%0d want=25", dc); end
    if (ord !== 8'h1B) begin bad++; $display("FAIL restart_order got=%h want=1b", ord); end
    if (pass !== 1'b1) begin bad++; $display("FAIL restart_pass got=%b want=1", pass); end
  endtask

  task automatic test_mid_reset;
    int dn, bn, dc;
    logic [7:0] ord;
    mode = 2'd0;
    dn = 0;
    @(negedge clk);
    start = 1'b1;
    for (int c = 1; c <= 15; c++) begin
      @(negedge clk);
      start = 1'b0;
    end
    total += 1;
    if ({a_drv[0], b_drv[0], busy} !== 3'b101) begin
      bad++; $display("FAIL midrst_pre got=%b want=101", {a_drv[0], b_drv[0], busy});
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    total += 4;
    if (a_drv !== 4'h0) begin bad++; $display("FAIL midrst_a got=%h want=0", a_drv); end
    if (b_drv !== 4'h0) begin bad++; $display("FAIL midrst_b got=%h want=0", b_drv); end
    if (busy !== 1'b0) begin bad++; $display("FAIL midrst_busy got=%b want=0", busy); end
    if (done !== 1'b0) begin bad++; $display("FAIL midrst_done got=%b want=0", done); end
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (done || busy) dn++;
    end
    total += 1;
    if (dn !== 0) begin bad++; $display("FAIL midrst_quiet got=%0d want=0", dn); end
    run(0, 0, 0, bn, dn, dc, ord);
    total += 4;
    if (bn !== 24) begin bad++; $display("FAIL midrst_rerun_busy got=%0d want=24", bn); end
    if (dc !== 25) begin bad++; $display("FAIL midrst_rerun_done got=%0d want=25", dc); end
    if (ord !== 8'h1B) begin bad++; $display("FAIL midrst_rerun_order got=%h want=1b", ord); end
    if ({pass, fail_mask} !== 5'b10000) begin bad++; $display("FAIL midrst_rerun_result got=%b want=10000", {pass, fail_mask}); end
  endtask

  task automatic test_slow_gate;
    int bn, dn, dc;
    logic [7:0] ord;
    mode = 2'd3;
    run(0, 0, 0, bn, dn, dc, ord);
    total += 2;
    if (fail_mask === 4'b0000) begin bad++; $display("FAIL slow_mask got=%b want=nonzero", fail_mask); end
    if (pass !== 1'b0) begin bad++; $display("FAIL slow_pass got=%b want=0", pass); end
  endtask

  initial begin
    test_reset;
    test_ideal;
    test_stuck_high;
    test_stuck_low_short;
    test_back_to_back;
    test_mid_reset;
    test_slow_gate;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
